// File: rtl/seven_segment_pkg.sv
// seven_segment_pkg: shared constants and hex glyph table for the scan mux
package seven_segment_pkg;
  localparam int bright_w = 4;
  localparam int n_sub = 16;
  localparam logic [15:0][6:0] glyphs = {
    7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };
  function automatic logic [6:0] hex_glyph(input logic [3:0] h);
    return glyphs[h];
  endfunction
endpackage

// File: rtl/seven_segment_scan_timer.sv
// seven_segment_scan_timer: slot/digit counters and frame capture pulse
module seven_segment_scan_timer
  import seven_segment_pkg::*;
#(
  parameter int w_digit = 8,
  parameter int sub_cycles = 256,
  localparam int slot_w = $clog2(n_sub * sub_cycles),
  localparam int idx_w = w_digit > 1 ? $clog2(w_digit) : 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [slot_w-1:0] slot_cnt,
  output logic [idx_w-1:0]  idx,
  output logic              capture,
  output logic              frame_start
);
  logic wrap;
  assign wrap = slot_cnt == slot_w'(n_sub * sub_cycles - 1);
  assign capture = slot_cnt == '0 && idx == '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      slot_cnt <= '0;
      idx <= '0;
      frame_start <= 1'b0;
    end else begin
      slot_cnt <= wrap ? '0 : slot_cnt + 1'b1;
      if (wrap) idx <= idx == idx_w'(w_digit - 1) ? '0 : idx + 1'b1;
      frame_start <= capture;
    end
endmodule

// File: rtl/seven_segment_scan_mux.sv
// seven_segment_scan_mux: tear-free multiplexed seven-segment driver with PWM,
// dead time, per-digit enable, leading-zero blanking and pin polarity
module seven_segment_scan_mux
  import seven_segment_pkg::*;
#(
  parameter int w_digit = 8,
  parameter int sub_cycles = 256,
  parameter int dead_cycles = 4,
  parameter bit seg_active_low = 1'b1,
  parameter bit an_active_low = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4*w_digit-1:0]   number,
  input  logic [w_digit-1:0]     dots,
  input  logic [w_digit-1:0]     digit_en,
  input  logic                   lz_blank,
  input  logic [bright_w-1:0]    brightness,
  output logic [6:0]             seg,
  output logic                   dp,
  output logic [w_digit-1:0]     an,
  output logic                   frame_start
);
  localparam int slot_w = $clog2(n_sub * sub_cycles);
  localparam int idx_w = w_digit > 1 ? $clog2(w_digit) : 1;
  localparam logic [6:0] seg_off = seg_active_low ? 7'h7F : 7'h00;
  localparam logic [w_digit-1:0] an_off = an_active_low ? '1 : '0;
  localparam logic [w_digit-1:0] an_one = w_digit'(1);
  logic [slot_w-1:0] slot_cnt;
  logic [idx_w-1:0] idx;
  logic capture;
  logic [4*w_digit-1:0] sh_num, e_num;
  logic [w_digit-1:0] sh_dots, sh_en, e_dots, e_en, lzb;
  logic sh_lz, e_lz;
  logic [bright_w-1:0] sh_br, e_br, p;
  logic [3:0] nib;
  logic lit;
  seven_segment_scan_timer #(.w_digit(w_digit), .sub_cycles(sub_cycles)) u_timer (
    .clk(clk),
    .rst(rst),
    .slot_cnt(slot_cnt),
    .idx(idx),
    .capture(capture),
    .frame_start(frame_start)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sh_num <= '0;
      sh_dots <= '0;
      sh_en <= '0;
      sh_lz <= 1'b0;
      sh_br <= '0;
    end else if (capture) begin
      sh_num <= number;
      sh_dots <= dots;
      sh_en <= digit_en;
      sh_lz <= lz_blank;
      sh_br <= brightness;
    end
  // On the capture cycle the pins already see the values being captured
  assign e_num = capture ? number : sh_num;
  assign e_dots = capture ? dots : sh_dots;
  assign e_en = capture ? digit_en : sh_en;
  assign e_lz = capture ? lz_blank : sh_lz;
  assign e_br = capture ? brightness : sh_br;
  always_comb begin
    lzb = '0;
    for (int k = 1; k < w_digit; k++) lzb[k] = e_lz && (e_num >> (4 * k)) == '0;
  end
  assign p = bright_w'(slot_cnt / slot_w'(sub_cycles));
  assign nib = e_num[4*idx +: 4];
  // A blanked digit still lights its anode when only its dp is to be shown
  assign lit = slot_cnt >= slot_w'(dead_cycles) && p <= e_br && e_en[idx] && (!lzb[idx] || e_dots[idx]);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      seg <= seg_off;
      dp <= seg_off[0];
      an <= an_off;
    end else begin
      seg <= (lit && !lzb[idx] ? hex_glyph(nib) : 7'h00) ^ seg_off;
      dp <= (lit && e_dots[idx]) ^ seg_off[0];
      an <= (lit ? an_one << idx : '0) ^ an_off;
    end
endmodule

// File: tb/tb_seven_segment_scan_mux.sv
// tb_seven_segment_scan_mux: randomized, model-checked bench for the scan mux
module tb_seven_segment_scan_mux;
  localparam int W = 8, SUB = 4, DEAD = 1, SLOT = 16 * SUB, FRAME = W * SLOT;
  localparam logic [6:0] glyph [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
  logic clk = 1'b0;
  logic rst;
  logic [31:0] number;
  logic [7:0] dots, digit_en;
  logic lz_blank;
  logic [3:0] brightness;
  logic [6:0] seg, seg4;
  logic dp, dp4, frame_start, fs4;
  logic [7:0] an;
  logic [3:0] an4;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  seven_segment_scan_mux #(.w_digit(W), .sub_cycles(SUB), .dead_cycles(DEAD),
    .seg_active_low(1'b1), .an_active_low(1'b1)) dut (
    .clk(clk), .rst(rst), .number(number), .dots(dots), .digit_en(digit_en),
    .lz_blank(lz_blank), .brightness(brightness), .seg(seg), .dp(dp), .an(an),
    .frame_start(frame_start));

  seven_segment_scan_mux #(.w_digit(4), .sub_cycles(SUB), .dead_cycles(DEAD),
    .seg_active_low(1'b0), .an_active_low(1'b0)) dut4 (
    .clk(clk), .rst(rst), .number(number[15:0]), .dots(dots[3:0]), .digit_en(digit_en[3:0]),
    .lz_blank(lz_blank), .brightness(brightness), .seg(seg4), .dp(dp4), .an(an4),
    .frame_start(fs4));

  // Reference: position in the frame is just cycles since release modulo the frame length
  logic [16:0] exp_bus = {8'hFF, 7'h7F, 1'b1, 1'b0};
  int ncyc = 0, m_t, m_d, m_s;
  logic [31:0] m_num;
  logic [7:0] m_dots, m_en;
  logic m_lz, m_blank, m_lit;
  logic [3:0] m_br;
  logic [6:0] m_seg;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ncyc = 0;
      exp_bus <= {8'hFF, 7'h7F, 1'b1, 1'b0};
    end else begin
      m_t = ncyc % FRAME;
      if (m_t == 0) begin
        m_num = number; m_dots = dots; m_en = digit_en; m_lz = lz_blank; m_br = brightness;
      end
      m_d = m_t / SLOT;
      m_s = m_t % SLOT;
      m_blank = m_lz && m_d > 0 && (m_num >> (4 * m_d)) == 32'h0;
      m_lit = m_s >= DEAD && (m_s / SUB) <= int'(m_br) && m_en[m_d] && (!m_blank || m_dots[m_d]);
      m_seg = (m_lit && !m_blank) ? glyph[m_num[4*m_d +: 4]] : 7'h00;
      exp_bus <= {~(m_lit ? 8'd1 << m_d : 8'h00), ~m_seg, ~(m_lit && m_dots[m_d]), m_t == 0};
      ncyc++;
    end
  end

  task automatic sync_frame();
    int n = 0;
    do begin @(negedge clk); n++; end while (frame_start !== 1'b1 && n < FRAME + 4);
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL sync_frame frame_start=%b after %0d cycles, need 1", frame_start, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({an, seg, dp, frame_start} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_pins got %h need %h", {an, seg, dp, frame_start}, {8'hFF, 7'h7F, 1'b1, 1'b0});
    end
    checks++;
    if ({an4, seg4, dp4, fs4} !== 13'h0) begin
      errors++;
      $display("FAIL reset_pins_w4 got %h need 0", {an4, seg4, dp4, fs4});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b1 || fs4 !== 1'b1 || {an, seg, dp, frame_start} !== exp_bus) begin
      errors++;
      $display("FAIL reset_first_capture fs=%b fs4=%b pins %h need %h", frame_start, fs4, {an, seg, dp, frame_start}, exp_bus);
    end
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_fs_width frame_start=%b need 0", frame_start);
    end
  endtask

  task automatic test_full_brightness();
    int on0 = 0;
    number = 32'h1234ABCD; brightness = 4'd15; digit_en = 8'hFF; dots = 8'h00; lz_blank = 1'b0;
    sync_frame();
    for (int i = 1; i <= FRAME; i++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, dp, frame_start} !== exp_bus) begin
        errors++;
        $display("FAIL full_model t=%0d got %h exp %h", i, {an, seg, dp, frame_start}, exp_bus);
      end
      if (i <= SLOT && an[0] === 1'b0) on0++;
      if (i == 1) begin
        checks++;
        if (an !== 8'hFE || seg !== ~7'b0111101) begin
          errors++;
          $display("FAIL full_slot0 an=%h seg=%h need FE %h", an, seg, ~7'b0111101);
        end
      end
      if (i == 7 * SLOT + 1) begin
        checks++;
        if (an !== 8'h7F || seg !== ~7'b0110000) begin
          errors++;
          $display("FAIL full_slot7 an=%h seg=%h need 7F %h", an, seg, ~7'b0110000);
        end
      end
    end
    checks++;
    if (on0 != SLOT - DEAD) begin
      errors++;
      $display("FAIL full_duty lit=%0d need %0d", on0, SLOT - DEAD);
    end
  endtask

  task automatic test_min_brightness();
    int lit = 0;
    brightness = 4'd0;
    sync_frame();
    for (int i = 1; i <= FRAME; i++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, dp, frame_start} !== exp_bus) begin
        errors++;
        $display("FAIL min_model t=%0d got %h exp %h", i, {an, seg, dp, frame_start}, exp_bus);
      end
      if (an !== 8'hFF) begin
        lit++;
        checks++;
        if (i % SLOT < 1 || i % SLOT > 3) begin
          errors++;
          $display("FAIL min_window slot_pos=%0d lit, need 1..3", i % SLOT);
        end
      end
    end
    checks++;
    if (lit != W * 3) begin
      errors++;
      $display("FAIL min_duty lit=%0d need %0d", lit, W * 3);
    end
  endtask

  task automatic test_lz_blank();
    logic [7:0] mask = 8'h00;
    number = 32'h00000A05; lz_blank = 1'b1; dots = 8'h10; brightness = 4'd15; digit_en = 8'hFF;
    sync_frame();
    for (int i = 1; i <= FRAME; i++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, dp, frame_start} !== exp_bus) begin
        errors++;
        $display("FAIL lz_model t=%0d got %h exp %h", i, {an, seg, dp, frame_start}, exp_bus);
      end
      mask = mask | ~an;
      if (an === 8'hEF) begin
        checks++;
        if (seg !== 7'h7F || dp !== 1'b0) begin
          errors++;
          $display("FAIL lz_dp_only seg=%h dp=%b need 7F 0", seg, dp);
        end
      end
      if (an === 8'hFD) begin
        checks++;
        if (seg !== ~7'h7E) begin
          errors++;
          $display("FAIL lz_inner_zero seg=%h need %h", seg, ~7'h7E);
        end
      end
    end
    checks++;
    if (mask !== 8'h17) begin
      errors++;
      $display("FAIL lz_lit_digits mask=%h need 17", mask);
    end
    lz_blank = 1'b0; dots = 8'h00;
  endtask

  task automatic test_anti_tearing();
    logic [31:0] n1 = $urandom, n2 = $urandom;
    number = n1; dots = 8'($urandom); brightness = 4'($urandom_range(15)); digit_en = 8'hFF; lz_blank = 1'b0;
    sync_frame();
    for (int i = 1; i <= FRAME + 1; i++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, dp, frame_start} !== exp_bus) begin
        errors++;
        $display("FAIL tear_model t=%0d got %h exp %h", i, {an, seg, dp, frame_start}, exp_bus);
      end
      if (i == 200) number = n2;
      if (i == 7 * SLOT + 1) begin
        checks++;
        if (seg !== ~glyph[n1[31:28]]) begin
          errors++;
          $display("FAIL tear_old_kept seg=%h need %h", seg, ~glyph[n1[31:28]]);
        end
      end
      if (i == FRAME + 1) begin
        checks++;
        if (seg !== ~glyph[n2[3:0]] || an !== 8'hFE) begin
          errors++;
          $display("FAIL tear_new_slot0 an=%h seg=%h need FE %h", an, seg, ~glyph[n2[3:0]]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, dp, frame_start} !== exp_bus) begin
        errors++;
        $display("FAIL rand_model i=%0d got %h exp %h", i, {an, seg, dp, frame_start}, exp_bus);
      end
      if ($urandom_range(99) == 0) begin
        number = $urandom & {8{($urandom_range(1) == 1) ? 4'hF : 4'h0}} & $urandom;
        dots = 8'($urandom); digit_en = 8'($urandom); lz_blank = 1'($urandom);
        brightness = 4'($urandom);
      end
    end
  endtask

  task automatic test_mid_reset();
    number = $urandom | 32'h0000_0F00; digit_en = 8'hFF; lz_blank = 1'b0; brightness = 4'd15; dots = 8'h00;
    sync_frame();
    sync_frame();
    repeat (2 * SLOT + 10) @(negedge clk);
    checks++;
    if (an !== 8'hFB) begin
      errors++;
      $display("FAIL mid_pre_reset an=%h need FB", an);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({an, seg, dp, frame_start} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL mid_async_dark got %h need %h", {an, seg, dp, frame_start}, {8'hFF, 7'h7F, 1'b1, 1'b0});
    end
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b1 || an !== 8'hFF) begin
      errors++;
      $display("FAIL mid_restart_capture fs=%b an=%h need 1 FF", frame_start, an);
    end
    @(negedge clk);
    checks++;
    if (an !== 8'hFE || {an, seg, dp, frame_start} !== exp_bus) begin
      errors++;
      $display("FAIL mid_restart_digit0 got %h exp %h", {an, seg, dp, frame_start}, exp_bus);
    end
  endtask

  task automatic test_w4();
    int last = -1, n = 0, k;
    number = $urandom; digit_en = 8'hFF; lz_blank = 1'b0; brightness = 4'd15; dots = 8'h00;
    do begin @(negedge clk); n++; end while (fs4 !== 1'b1 && n < 300);
    do begin @(negedge clk); n++; end while (fs4 !== 1'b1 && n < 600);
    checks++;
    if (fs4 !== 1'b1) begin
      errors++;
      $display("FAIL w4_sync fs4=%b need 1", fs4);
    end
    for (int i = 0; i < 3 * 256 + 10; i++) begin
      @(negedge clk);
      checks++;
      if ($countones(an4) > 1) begin
        errors++;
        $display("FAIL w4_onehot an4=%b", an4);
      end
      if (fs4 === 1'b1) begin
        if (last >= 0) begin
          checks++;
          if (i - last != 256) begin
            errors++;
            $display("FAIL w4_period got %0d need 256", i - last);
          end
        end
        last = i;
      end
      if ($countones(an4) == 1) begin
        k = $clog2(an4);
        checks++;
        if (seg4 !== glyph[number[4*k +: 4]] || dp4 !== 1'b0) begin
          errors++;
          $display("FAIL w4_glyph digit=%0d seg4=%h need %h", k, seg4, glyph[number[4*k +: 4]]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    number = 32'h1234ABCD; dots = 8'h00; digit_en = 8'hFF; lz_blank = 1'b0; brightness = 4'd15;
    test_reset();
    test_full_brightness();
    test_min_brightness();
    test_lz_blank();
    test_anti_tearing();
    test_random();
    test_mid_reset();
    test_w4();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
